// File: rtl/spi_slave.sv
// SPI mode-0 slave with synchronized inputs, one-entry transmit buffer and word-level rx handshake.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first shifting in both directions (default MSB first).
module spi_slave #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_udr
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall;

  state_t                 state;
  logic [CW-1:0]          bit_cnt;
  logic                   word_done;
  logic [WIDTH-1:0]       tx_sh;
  logic [WIDTH-2:0]       rx_part;
  logic [WIDTH-1:0]       rx_next;
  logic [WIDTH-1:0]       tx_shifted;
  logic [WIDTH-1:0]       buf_data;

  // Input synchronizers, idle values on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign cs_fall   = ~cs_s & cs_prev;

`ifdef SPI_SLAVE_LSB_FIRST_EN
  assign rx_next    = {mosi_s, rx_part};
  assign tx_shifted = {1'b0, tx_sh[WIDTH-1:1]};
  assign miso       = tx_sh[0];
`else
  assign rx_next    = {rx_part, mosi_s};
  assign tx_shifted = {tx_sh[WIDTH-2:0], 1'b0};
  assign miso       = tx_sh[WIDTH-1];
`endif

  // Frame FSM, transmit buffer and receive assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      word_done <= 1'b0;
      tx_sh     <= '0;
      rx_part   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_udr    <= 1'b0;
      buf_data  <= '0;
      tx_ready  <= 1'b1;
      miso_oe   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_udr   <= 1'b0;
      miso_oe  <= ~cs_s;

      if (tx_valid && tx_ready) begin
        buf_data <= tx_data;
        tx_ready <= 1'b0;
      end

      if (cs_s) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        word_done <= 1'b0;
        tx_sh     <= '0;
      end else begin
        case (state)
          IDLE: if (cs_fall) state <= LOAD;
          LOAD: begin
            state     <= SHIFT;
            word_done <= 1'b0;
            // A capture this cycle only happens when the buffer was empty, so it never collides here
            if (!tx_ready) begin
              tx_sh    <= buf_data;
              tx_ready <= 1'b1;
            end else begin
              tx_sh  <= '0;
              tx_udr <= 1'b1;
            end
          end
          SHIFT: begin
            if (sclk_fall) begin
              tx_sh <= tx_shifted;
              if (word_done) state <= LOAD;
            end
          end
          default: state <= IDLE;
        endcase

        if (state != IDLE && sclk_rise) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
          rx_part <= rx_next[WIDTH-1:1];
`else
          rx_part <= rx_next[WIDTH-2:0];
`endif
          if (bit_cnt == CW'(WIDTH - 1)) begin
            rx_data   <= rx_next;
            rx_valid  <= 1'b1;
            bit_cnt   <= '0;
            word_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: bus-functional SPI master, word-level reference expectations.
module tb_spi_slave;

  localparam int unsigned W = 8;
`ifdef SPI_SLAVE_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, sclk, cs_n, mosi;
  logic         miso, miso_oe, tx_valid, tx_ready, rx_valid, tx_udr;
  logic [W-1:0] tx_data, rx_data;

  int total = 0;
  int bad   = 0;
  int udr_seen = 0;
  int udr_exp  = 0;
  logic [W-1:0] exp_rx_q[$];
  logic [W-1:0] mon_e;

  logic [W-1:0] fr_mosi[4];
  logic [W-1:0] fr_tx[4];
  bit           fr_has[4];

  spi_slave #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .tx_udr(tx_udr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rx_valid pulse must match the next queued word
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid) begin
        if (exp_rx_q.size() == 0) begin
          chk("rx_unexpected", 32'(rx_valid), 32'(0));
        end else begin
          mon_e = exp_rx_q.pop_front();
          chk("rx_data", 32'(rx_data), 32'(mon_e));
        end
      end
      if (tx_udr) udr_seen++;
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_buf(input logic [W-1:0] w);
    int n = 0;
    while (!tx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("buf_ready", 32'(tx_ready), 32'(1));
    tx_data  = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("buf_full", 32'(tx_ready), 32'(0));
  endtask

  // One word of nbits with sclk = clk/8; optionally queues the next tx word during bit 1
  task automatic send_word(input logic [W-1:0] mw, input int nbits, input bit do_q,
                           input logic [W-1:0] qword, output logic [W-1:0] got,
                           output logic [W-1:0] mask);
    got  = '0;
    mask = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx;
      idx = LSB ? i : int'(W) - 1 - i;
      mosi = mw[idx];
      @(negedge clk);
      if (do_q && i == 1) begin
        tx_data  = qword;
        tx_valid = 1'b1;
      end
      @(negedge clk);
      tx_valid = 1'b0;
      wait_clk(2);
      got[idx]  = miso;
      mask[idx] = 1'b1;
      sclk = 1'b1;
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input int nw, input int abort_bits);
    logic [W-1:0] got, mask, expw;
    int nb;
    nb = (abort_bits != 0) ? abort_bits : int'(W);
    if (fr_has[0]) write_buf(fr_tx[0]);
    cs_n = 1'b0;
    wait_clk(8);
    chk("miso_oe_active", 32'(miso_oe), 32'(1));
    chk("tx_ready_after_load", 32'(tx_ready), 32'(1));
    for (int k = 0; k < nw; k++) begin
      if (!fr_has[k]) udr_exp++;
      if (abort_bits == 0) exp_rx_q.push_back(fr_mosi[k]);
      send_word(fr_mosi[k], nb, (k + 1 < nw) && fr_has[k+1], fr_tx[k+1], got, mask);
      expw = fr_has[k] ? fr_tx[k] : '0;
      chk("miso_word", 32'(got & mask), 32'(expw & mask));
    end
    wait_clk(4);
    if (abort_bits == 0) udr_exp++;
    cs_n = 1'b1;
    wait_clk(8);
    chk("miso_oe_idle", 32'(miso_oe), 32'(0));
  endtask

  task automatic set_fr(input int k, input logic [W-1:0] m, input bit h, input logic [W-1:0] t);
    fr_mosi[k] = m;
    fr_has[k]  = h;
    fr_tx[k]   = t;
  endtask

  initial begin
    logic [W-1:0] g, mk;
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    for (int k = 0; k < 4; k++) set_fr(k, '0, 1'b0, '0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(3);
    chk("rst_tx_ready", 32'(tx_ready), 32'(1));
    chk("rst_miso_oe", 32'(miso_oe), 32'(0));
    chk("rst_rx_data", 32'(rx_data), 32'(0));
    chk("rst_miso", 32'(miso), 32'(0));
    chk("rst_rx_valid", 32'(rx_valid), 32'(0));
    chk("rst_tx_udr", 32'(tx_udr), 32'(0));

    // Single word, buffered tx
    set_fr(0, 8'h3C, 1'b1, 8'hA5);
    run_frame(1, 0);
    // Back-to-back words with the second tx word queued mid-word
    set_fr(0, 8'h11, 1'b1, 8'hA5);
    set_fr(1, 8'h22, 1'b1, 8'h5A);
    run_frame(2, 0);
    // Underrun at frame start
    set_fr(0, 8'h3C, 1'b0, 8'h00);
    set_fr(1, 8'h00, 1'b0, 8'h00);
    run_frame(1, 0);
    // Aborted word, then a clean frame
    set_fr(0, 8'hFF, 1'b1, 8'hC3);
    run_frame(1, 5);
    set_fr(0, 8'h81, 1'b1, 8'h7E);
    run_frame(1, 0);
    chk("rx_after_abort", 32'(rx_data), 32'(8'h81));

    // sclk toggling with cs_n high is ignored
    for (int i = 0; i < 16; i++) begin
      mosi = i[0];
      sclk = ~sclk;
      wait_clk(4);
    end
    sclk = 1'b0;
    wait_clk(4);
    chk("rx_hold_cs_high", 32'(rx_data), 32'(8'h81));

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      int nw, ab;
      nw = int'($urandom_range(1, 3));
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W - 1)) : 0;
      if (ab != 0) nw = 1;
      for (int k = 0; k < 4; k++)
        set_fr(k, W'($urandom), 1'($urandom), W'($urandom));
      run_frame(nw, ab);
    end

    // Reset in the middle of a word
    cs_n = 1'b0;
    wait_clk(8);
    udr_exp++;
    send_word(8'hB7, 5, 1'b0, '0, g, mk);
    rst_n = 1'b0;
    cs_n  = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(4);
    chk("rx_after_rst", 32'(rx_data), 32'(0));
    chk("tx_ready_after_rst", 32'(tx_ready), 32'(1));
    set_fr(0, 8'h42, 1'b1, 8'h99);
    run_frame(1, 0);

    wait_clk(10);
    chk("rx_pending", 32'(exp_rx_q.size()), 32'(0));
    chk("udr_count", 32'(udr_seen), 32'(udr_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter WIDTH, default 8: bits per SPI word.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop stages on sclk, cs_n and mosi (minimum 2).
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-006 cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-007 mosi  input  1  master-out data.
REQ-008 miso  output  1  slave-out data.
REQ-009 miso_oe  output  1  miso output enable; high only while synchronized cs_n is low.
REQ-010 tx_data  input  WIDTH  word to send.
REQ-011 tx_valid  input  1  tx_data valid.
REQ-012 tx_ready  output  1  transmit buffer empty.
REQ-013 rx_data  output  WIDTH  last complete received word.
REQ-014 rx_valid  output  1  one-clk pulse: rx_data updated.
REQ-015 tx_udr  output  1  one-clk pulse: word loaded while transmit buffer empty.

Function
REQ-016 SPI mode 0 only: mosi sampled on synchronized sclk rising edge, miso changes on synchronized sclk falling edge; sclk frequency SHALL be at most clk/8.
REQ-017 Edges SHALL be detected by comparing the last two synchronizer outputs; all decisions use synchronized signals only.
REQ-018 States: IDLE (cs_n high), LOAD (one clk), SHIFT; IDLE->LOAD on cs_n fall; LOAD->SHIFT always; SHIFT->LOAD after WIDTH-th falling sclk edge; any state->IDLE on cs_n rise.
REQ-019 LOAD: shift register <= transmit buffer and buffer marked empty if full; else shift register <= 0 and tx_udr pulses.
REQ-020 Transmit buffer: one entry; capture when tx_valid && tx_ready; tx_ready = buffer empty, combinationally free of tx_valid.
REQ-021 Capture and LOAD consumption in the same cycle: LOAD takes old buffer content, new word is written, buffer stays full.
REQ-022 miso SHALL present shift-register bit WIDTH-1 from LOAD onward; register shifts left on each falling edge in SHIFT.
REQ-023 Bit counter 0..WIDTH-1 increments on each rising edge; on WIDTH-th rising edge rx_data <= assembled word and rx_valid pulses the next clk (SYNC_STAGES+1 clk after pin edge), counter wraps to 0.
REQ-024 Back-to-back words within one cs_n low period SHALL be supported without gaps.
REQ-025 cs_n rise mid-word: partial word discarded, no rx_valid, counter cleared, word already loaded from buffer lost.
REQ-026 sclk edges while cs_n high SHALL be ignored.

Reset
REQ-027 On rst_n low: state IDLE, counter 0, synchronizers to idle (sclk 0, cs_n 1, mosi 0), buffer empty.
REQ-028 Reset outputs: miso 0, miso_oe 0, tx_ready 1, rx_data 0, rx_valid 0, tx_udr 0.
REQ-029 Reset mid-transfer aborts immediately; bits received before reset never appear on rx_data.

Configuration
REQ-030 Macro SPI_SLAVE_LSB_FIRST_EN defined: both directions LSB first (miso shows bit 0, shift right, mosi enters at bit WIDTH-1).
REQ-031 Macro undefined: MSB first as REQ-022/REQ-023; interface identical in both builds.

Verification
REQ-032 Reset, no activity -> tx_ready=1, miso_oe=0, rx_data=0x00, no pulses.
REQ-033 Write 0xA5 to buffer, master sends 0x3C with sclk=clk/8 -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C with one rx_valid; tx_ready=1 after LOAD.
REQ-034 Two words in one frame, 0x5A queued during first word -> rx pulses for 0x11 then 0x22; miso carries 0xA5 then 0x5A, no gap.
REQ-035 Buffer empty at cs_n fall -> tx_udr pulse, miso all zeros, rx still 0x3C.
REQ-036 cs_n rises after 5 bits, then full 0x81 frame -> exactly one rx_valid, rx_data=0x81.
REQ-037 With SPI_SLAVE_LSB_FIRST_EN, send 0x01 with tx 0x80 -> rx_data=0x01, miso first bit 0, last bit 1.
